// File: rtl/acumulador_8_bit.sv
// acumulador_8_bit: block accumulator of N_SAMPLES adder results with flag counters and a result handshake
module acumulador_8_bit #(
  parameter int L         = 8,
  parameter int N_SAMPLES = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clr,
  input  logic signed [L-1:0] S,
  input  logic                Z,
  input  logic                N,
  input  logic                P,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [L-1:0] ACC,
  output logic                ACC_Z,
  output logic                ACC_N,
  output logic                ACC_P,
  output logic                OVF,
  output logic [3:0]          ZCNT,
  output logic [3:0]          NCNT,
  output logic [3:0]          ECNT,
  output logic [3:0]          CNT,
  output logic                out_valid,
  input  logic                out_ready
);
  typedef enum logic {ACCUM, DONE} state_t;
  state_t state, state_nx;
  logic signed [L-1:0] acc_nx, sum;
  logic ovf_nx, xfer, wipe;
  logic [3:0] cnt_nx, zcnt_nx, ncnt_nx, ecnt_nx;
  assign in_ready  = state == ACCUM;
  assign out_valid = state == DONE;
  assign xfer      = in_valid & in_ready & ~clr;
  assign wipe      = clr | (out_valid & out_ready);
  assign sum       = ACC + S;
  assign ACC_Z     = ACC == '0;
  assign ACC_N     = ACC[L-1];
  assign ACC_P     = ~ACC[0];
  always_comb begin
    state_nx = state;
    acc_nx   = ACC;
    ovf_nx   = OVF;
    cnt_nx   = CNT;
    zcnt_nx  = ZCNT;
    ncnt_nx  = NCNT;
    ecnt_nx  = ECNT;
    if (wipe) begin
      state_nx = ACCUM;
      acc_nx   = '0;
      ovf_nx   = 1'b0;
      cnt_nx   = '0;
      zcnt_nx  = '0;
      ncnt_nx  = '0;
      ecnt_nx  = '0;
    end else if (xfer) begin
      acc_nx   = sum;
      ovf_nx   = OVF | ((ACC[L-1] == S[L-1]) & (sum[L-1] != ACC[L-1]));
      cnt_nx   = CNT + 4'd1;
      zcnt_nx  = ZCNT + {3'b0, Z};
      ncnt_nx  = NCNT + {3'b0, N};
      ecnt_nx  = ECNT + {3'b0, P};
      state_nx = (CNT == 4'(N_SAMPLES - 1)) ? DONE : ACCUM;
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ACCUM;
      ACC   <= '0;
      OVF   <= 1'b0;
      CNT   <= '0;
      ZCNT  <= '0;
      NCNT  <= '0;
      ECNT  <= '0;
    end else begin
      state <= state_nx;
      ACC   <= acc_nx;
      OVF   <= ovf_nx;
      CNT   <= cnt_nx;
      ZCNT  <= zcnt_nx;
      NCNT  <= ncnt_nx;
      ECNT  <= ecnt_nx;
    end
  end
endmodule

// File: tb/tb_acumulador_8_bit.sv
// tb_acumulador_8_bit: directed self-checking bench for acumulador_8_bit (L=8, N_SAMPLES=4)
module tb_acumulador_8_bit;
  logic clock = 1'b0, reset_n = 1'b0, clr = 1'b0;
  logic [7:0] S = '0, acc;
  logic Z = 1'b0, N = 1'b0, P = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, acc_z, acc_n, acc_p, ovf, out_valid;
  logic [3:0] zcnt, ncnt, ecnt, cnt;
  int passed = 0, total = 0;

  acumulador_8_bit #(.L(8), .N_SAMPLES(4)) dut (
    .clock(clock), .reset_n(reset_n), .clr(clr), .S(S), .Z(Z), .N(N), .P(P),
    .in_valid(in_valid), .in_ready(in_ready), .ACC(acc), .ACC_Z(acc_z), .ACC_N(acc_n),
    .ACC_P(acc_p), .OVF(ovf), .ZCNT(zcnt), .NCNT(ncnt), .ECNT(ecnt), .CNT(cnt),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // flags as the upstream adder would produce them: P marks an even value
  task automatic smp(input logic [7:0] s);
    S = s; Z = (s == 8'h00); N = s[7]; P = ~s[0]; in_valid = 1'b1;
    cyc();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_acc"}, acc, 8'h00);
    chk({tag, "_flags"}, {acc_z, acc_n, acc_p, ovf}, 4'b1010);
    chk({tag, "_counts"}, {cnt, zcnt, ncnt, ecnt}, 16'h0000);
    chk({tag, "_hs"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    #12;
    chk_reset_state("reset");
    reset_n = 1'b1;
    cyc();
    chk_reset_state("post_reset");

    smp(8'd10);
    chk("b1_acc1", acc, 8'd10);
    smp(8'hFD);
    smp(8'd5);
    chk("b1_ov_before", out_valid, 1'b0);
    smp(8'd0);
    in_valid = 1'b0;
    chk("b1_hs", {in_ready, out_valid}, 2'b01);
    chk("b1_acc", acc, 8'h0C);
    chk("b1_counts", {cnt, zcnt, ncnt, ecnt}, 16'h4112);
    chk("b1_flags", {acc_z, acc_n, acc_p, ovf}, 4'b0010);

    S = 8'd7; Z = 1'b0; N = 1'b0; P = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    chk("hold_acc", acc, 8'h0C);
    chk("hold_counts", {cnt, zcnt, ncnt, ecnt}, 16'h4112);
    chk("hold_hs", {in_ready, out_valid}, 2'b01);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    chk("release_acc", acc, 8'h00);
    chk("release_cnt", cnt, 4'd0);
    chk("release_hs", {in_ready, out_valid}, 2'b10);

    smp(8'd100);
    chk("b2_ovf1", ovf, 1'b0);
    smp(8'd100);
    chk("b2_ovf2", ovf, 1'b1);
    chk("b2_acc2", acc, 8'hC8);
    smp(8'd0);
    smp(8'd0);
    in_valid = 1'b0;
    chk("b2_acc", acc, 8'hC8);
    chk("b2_flags", {acc_z, acc_n, acc_p, ovf}, 4'b0111);
    chk("b2_hs", {in_ready, out_valid}, 2'b01);

    #3 reset_n = 1'b0;
    #1;
    chk_reset_state("async_reset");
    cyc();
    reset_n = 1'b1;
    cyc();
    chk_reset_state("after_async");

    smp(8'd3);
    smp(8'd4);
    chk("clr_pre_acc", acc, 8'd7);
    chk("clr_pre_cnt", cnt, 4'd2);
    S = 8'd9; Z = 1'b0; N = 1'b0; P = 1'b0; clr = 1'b1;
    cyc();
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_acc", acc, 8'h00);
    chk("clr_counts", {cnt, zcnt, ncnt, ecnt}, 16'h0000);
    smp(8'd1);
    in_valid = 1'b0;
    chk("clr_resume", {acc, cnt}, 12'h011);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
